// File: rtl/fifo_arbiter_pkg.sv
// rtl/fifo_arbiter_pkg.sv - shared types and helpers for the FIFO write-side arbiter
package fifo_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_XFER,
        ARB_GAP
    } arb_state_t;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational round-robin picker, searching from last_ptr_i+1 with wrap
module rr_priority_picker
    import fifo_arbiter_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    localparam int ID_WIDTH = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req_i,
    input  logic [ID_WIDTH-1:0] last_ptr_i,
    output logic [NUM_REQ-1:0]  grant_o,
    output logic [ID_WIDTH-1:0] index_o,
    output logic                any_o
);

    always_comb begin
        int idx;
        grant_o = '0;
        index_o = '0;
        any_o   = 1'b0;
        idx     = 0;
        // Walk from the farthest offset down so the nearest valid requester wins last.
        for (int off = NUM_REQ; off >= 1; off--) begin
            idx = (int'(last_ptr_i) + off) % NUM_REQ;
            if (req_i[idx]) begin
                grant_o      = '0;
                grant_o[idx] = 1'b1;
                index_o      = ID_WIDTH'(idx);
                any_o        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - round-robin, burst-limited sharing of one FIFO write port, paced to one write per two cycles
module fifo_write_arbiter
    import fifo_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4,
    localparam int ID_WIDTH  = id_width(NUM_REQ)
) (
    input  logic                           i_Clock,
    input  logic                           i_Reset,
    input  logic [NUM_REQ-1:0]             i_ReqValid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  i_ReqData,
    output logic [NUM_REQ-1:0]             o_ReqReady,
    output logic [DATA_WIDTH+ID_WIDTH-1:0] o_WrData,
    output logic                           o_WrEnable,
    input  logic                           i_FifoFull,
    output logic [NUM_REQ-1:0]             o_Grant,
    output logic                           o_Busy
);

    localparam int CNT_W = $clog2(BURST_LEN + 1);

    arb_state_t                     state_q, state_d;
    logic [NUM_REQ-1:0]             grant_q, grant_d;
    logic [ID_WIDTH-1:0]            grant_idx_q, grant_idx_d;
    logic [ID_WIDTH-1:0]            last_ptr_q, last_ptr_d;
    logic [CNT_W-1:0]               beat_cnt_q, beat_cnt_d;
    logic [DATA_WIDTH+ID_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                           wr_en_q, wr_en_d;

    logic [NUM_REQ-1:0]  pick_grant;
    logic [ID_WIDTH-1:0] pick_idx;
    logic                pick_any;
    logic                cur_valid;
    logic [DATA_WIDTH-1:0] cur_data;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req_i      (i_ReqValid),
        .last_ptr_i (last_ptr_q),
        .grant_o    (pick_grant),
        .index_o    (pick_idx),
        .any_o      (pick_any)
    );

    assign cur_valid = i_ReqValid[grant_idx_q];
    assign cur_data  = i_ReqData[grant_idx_q*DATA_WIDTH +: DATA_WIDTH];

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        grant_idx_d = grant_idx_q;
        last_ptr_d  = last_ptr_q;
        beat_cnt_d  = beat_cnt_q;
        wr_data_d   = wr_data_q;
        wr_en_d     = 1'b0;
        o_ReqReady  = '0;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    grant_d     = pick_grant;
                    grant_idx_d = pick_idx;
                    state_d     = ARB_XFER;
                end
            end
            ARB_XFER: begin
                if (!cur_valid) begin
                    last_ptr_d = grant_idx_q;
                    grant_d    = '0;
                    beat_cnt_d = '0;
                    state_d    = ARB_IDLE;
                end else if (!i_FifoFull) begin
                    o_ReqReady[grant_idx_q] = 1'b1;
                    wr_data_d  = {grant_idx_q, cur_data};
                    wr_en_d    = 1'b1;
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    state_d    = ARB_GAP;
                end
            end
            ARB_GAP: begin
                // The registered strobe is high during this cycle; full is re-read on return to XFER.
                if (beat_cnt_q == CNT_W'(BURST_LEN)) begin
                    last_ptr_d = grant_idx_q;
                    grant_d    = '0;
                    beat_cnt_d = '0;
                    state_d    = ARB_IDLE;
                end else begin
                    state_d = ARB_XFER;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q     <= ARB_IDLE;
            grant_q     <= '0;
            grant_idx_q <= '0;
            last_ptr_q  <= ID_WIDTH'(NUM_REQ - 1);
            beat_cnt_q  <= '0;
            wr_data_q   <= '0;
            wr_en_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            last_ptr_q  <= last_ptr_d;
            beat_cnt_q  <= beat_cnt_d;
            wr_data_q   <= wr_data_d;
            wr_en_q     <= wr_en_d;
        end
    end

    assign o_WrData   = wr_data_q;
    assign o_WrEnable = wr_en_q;
    assign o_Grant    = grant_q;
    assign o_Busy     = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb/tb_fifo_write_arbiter.sv - scoreboard bench for fifo_write_arbiter
module tb_fifo_write_arbiter;

    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int IW    = 2;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      valid;
    logic [N*DW-1:0]   data;
    logic [N-1:0]      ready;
    logic [DW+IW-1:0]  wdata;
    logic              wen;
    logic              full;
    logic [N-1:0]      grant;
    logic              busy;

    always #5 clk = ~clk;

    fifo_write_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .BURST_LEN  (4)
    ) dut (
        .i_Clock    (clk),
        .i_Reset    (rst),
        .i_ReqValid (valid),
        .i_ReqData  (data),
        .o_ReqReady (ready),
        .o_WrData   (wdata),
        .o_WrEnable (wen),
        .i_FifoFull (full),
        .o_Grant    (grant),
        .o_Busy     (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0]    src_q [N][$];
    logic [DW+IW-1:0] sb[$];
    int               log_src[$];
    int               log_cyc[$];
    bit [N-1:0]       en;
    bit               rst_req, force_full, use_model, wen_prev;
    int               fcount, cyc;
    logic [N-1:0]     s_ready, s_grant;
    logic             s_busy, s_wen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int pending();
        int s = 0;
        for (int k = 0; k < N; k++) s += src_q[k].size();
        return s;
    endfunction

    task automatic cycle();
        @(negedge clk);
        rst = rst_req;
        for (int k = 0; k < N; k++) begin
            if (en[k] && src_q[k].size() > 0) begin
                valid[k]          = 1'b1;
                data[k*DW +: DW]  = src_q[k][0];
            end else begin
                valid[k] = 1'b0;
            end
        end
        full = use_model ? (fcount >= DEPTH) : force_full;
        #1;
        s_ready = ready; s_grant = grant; s_busy = busy; s_wen = wen;
        if (wen) begin
            check("wr_b2b", 32'(wen_prev), 0);
            check("wr_full", 32'(full), 0);
            check("sb_nonempty", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) check("wr_data", 32'(wdata), 32'(sb.pop_front()));
            log_src.push_back(int'(wdata[DW +: IW]));
            log_cyc.push_back(cyc);
            if (use_model) fcount++;
        end
        wen_prev = wen;
        check("rdy_subset", 32'(ready & ~(valid & grant)), 0);
        if (full) check("rdy_full", 32'(ready), 0);
        check("busy_grant", 32'(busy), 32'(|grant));
        if (!rst) begin
            for (int k = 0; k < N; k++)
                if (valid[k] && ready[k]) sb.push_back({IW'(k), src_q[k].pop_front()});
        end
        if (use_model && fcount > 0 && $urandom_range(0, 2) == 0) fcount--;
        cyc++;
    endtask

    task automatic do_reset();
        rst_req = 1'b1;
        cycle();
        cycle();
        rst_req = 1'b0;
        log_src.delete();
        log_cyc.delete();
    endtask

    task automatic run_until_writes(input int n, input int budget);
        int b = budget;
        while (log_src.size() < n && b > 0) begin
            cycle();
            b--;
        end
        check("write_timeout", 32'(log_src.size() >= n), 1);
    endtask

    task automatic finish_test(input int budget);
        int b = budget;
        while ((pending() > 0 || sb.size() > 0) && b > 0) begin
            cycle();
            b--;
        end
        repeat (3) cycle();
        check("drain_sb", 32'(sb.size()), 0);
        check("drain_src", 32'(pending()), 0);
    endtask

    task automatic fill(input int k, input int n);
        for (int i = 0; i < n; i++) src_q[k].push_back(DW'($urandom));
    endtask

    initial begin
        rst = 1'b1; valid = '0; data = '0; full = 1'b0;
        en = '0; rst_req = 1'b1; force_full = 1'b0; use_model = 1'b0;
        wen_prev = 1'b0; fcount = 0; cyc = 0;

        // 1: all four requesters busy, FIFO never full
        do_reset();
        check("rst_grant", 32'(s_grant), 0);
        check("rst_busy", 32'(s_busy), 0);
        check("rst_wen", 32'(s_wen), 0);
        check("rst_ready", 32'(s_ready), 0);
        check("rst_wdata", 32'(wdata), 0);
        for (int k = 0; k < N; k++) fill(k, 8);
        en = 4'b1111;
        run_until_writes(20, 200);
        for (int i = 0; i < 20 && i < log_src.size(); i++) begin
            check("t1_order", 32'(log_src[i]), 32'((i / 4) % 4));
            if (i % 4 != 0) check("t1_pace", 32'(log_cyc[i] - log_cyc[i-1]), 2);
        end
        finish_test(400);

        // 2: single requester with more words than one burst
        en = '0;
        do_reset();
        fill(2, 6);
        en = 4'b0100;
        run_until_writes(6, 100);
        check("t2_count", 32'(log_src.size()), 6);
        for (int i = 0; i < log_src.size(); i++) check("t2_src", 32'(log_src[i]), 2);
        if (log_cyc.size() >= 6) begin
            check("t2_pace", 32'(log_cyc[3] - log_cyc[2]), 2);
            check("t2_regrant", 32'(log_cyc[4] - log_cyc[3]), 3);
            check("t2_pace2", 32'(log_cyc[5] - log_cyc[4]), 2);
        end
        finish_test(100);

        // 3: FIFO full for 5 cycles mid-burst
        en = '0;
        do_reset();
        fill(0, 6);
        en = 4'b0001;
        run_until_writes(2, 50);
        force_full = 1'b1;
        repeat (5) begin
            cycle();
            check("t3_ready", 32'(s_ready), 0);
            check("t3_wen", 32'(s_wen), 0);
            check("t3_grant", 32'(s_grant), 32'h1);
        end
        force_full = 1'b0;
        cycle();
        check("t3_resume", 32'(s_ready), 32'h1);
        run_until_writes(6, 100);
        if (log_cyc.size() >= 5) begin
            check("t3_stall_gap", 32'(log_cyc[2] - log_cyc[1]), 7);
            check("t3_pace", 32'(log_cyc[3] - log_cyc[2]), 2);
            check("t3_burst_end", 32'(log_cyc[4] - log_cyc[3]), 3);
        end
        finish_test(100);

        // 4: owner drops valid, pending requester must be served next
        en = '0;
        do_reset();
        fill(1, 5);
        fill(3, 4);
        en = 4'b1010;
        run_until_writes(2, 50);
        en[1] = 1'b0;
        cycle();
        en[1] = 1'b1;
        run_until_writes(9, 200);
        begin
            int exp4 [9] = '{1, 1, 3, 3, 3, 3, 1, 1, 1};
            for (int i = 0; i < 9 && i < log_src.size(); i++)
                check("t4_order", 32'(log_src[i]), 32'(exp4[i]));
        end
        finish_test(100);

        // 5: reset in the cycle a beat is accepted
        en = '0;
        do_reset();
        fill(2, 3);
        fill(0, 2);
        en = 4'b0100;
        cycle();
        rst_req = 1'b1;
        cycle();
        check("t5_rst_beat", 32'(s_ready), 32'h4);
        rst_req = 1'b0;
        en = 4'b0101;
        cycle();
        check("t5_wen", 32'(s_wen), 0);
        check("t5_grant", 32'(s_grant), 0);
        check("t5_busy", 32'(s_busy), 0);
        log_src.delete();
        log_cyc.delete();
        run_until_writes(1, 50);
        if (log_src.size() > 0) check("t5_first", 32'(log_src[0]), 0);
        finish_test(200);
        check("t5_total", 32'(log_src.size()), 5);

        // 6: random valid pattern against a modelled FIFO with random drain
        en = '0;
        do_reset();
        use_model = 1'b1;
        fcount = 0;
        for (int k = 0; k < N; k++) fill(k, 60);
        for (int i = 0; i < 1000; i++) begin
            en = N'($urandom);
            cycle();
        end
        en = 4'b1111;
        finish_test(5000);
        check("t6_total", 32'(log_src.size()), 240);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
